// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between an
// instruction-fetch port and a load/store port. Data accesses win by
// default; a starvation counter hands the memory to the fetch port after
// STARVE_MAX consecutive denied cycles. Reads return one cycle after grant.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_req,
    input  logic [31:0] imem_addr,
    output logic        imem_gnt,
    output logic        imem_rvalid,
    output logic [31:0] imem_rdata,
    input  logic        dmem_req,
    input  logic        dmem_we,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic        dmem_gnt,
    output logic        dmem_rvalid,
    output logic [31:0] dmem_rdata,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    // Owner of the read whose data arrives on mem_rdata this cycle.
    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_IMEM,
        TAG_DMEM
    } tag_e;

    logic [CNT_W-1:0] starve_q, starve_d;
    tag_e             tag_q, tag_d;
    logic [31:0]      imem_hold_q, imem_hold_d;
    logic [31:0]      dmem_hold_q, dmem_hold_d;
    logic             imem_starved;

    // Arbitration and steering of the granted request onto the memory port.
    always_comb begin
        imem_starved = imem_req && (starve_q == CNT_MAX);
        dmem_gnt     = rst && dmem_req && !imem_starved;
        imem_gnt     = rst && imem_req && !dmem_gnt;
        mem_en       = imem_gnt | dmem_gnt;
        mem_addr     = dmem_gnt ? dmem_addr[31:2] : imem_addr[31:2];
        mem_we       = (dmem_gnt && dmem_we) ? dmem_wstrb : 4'b0000;
        mem_wdata    = dmem_wdata;
    end

    // Read return: the tag selects who sees mem_rdata; a pending read is
    // dropped while reset is asserted.
    assign imem_rvalid = rst && (tag_q == TAG_IMEM);
    assign dmem_rvalid = rst && (tag_q == TAG_DMEM);
    assign imem_rdata  = imem_rvalid ? mem_rdata : imem_hold_q;
    assign dmem_rdata  = dmem_rvalid ? mem_rdata : dmem_hold_q;

    // Next state for the starvation counter, read tag and delivered-data holds.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        starve_d    = '0;
        tag_d       = TAG_NONE;
        imem_hold_d = imem_hold_q;
        dmem_hold_d = dmem_hold_q;

        if (imem_req && !imem_gnt) begin
            starve_d = (starve_q == CNT_MAX) ? starve_q : starve_q + CNT_W'(1);
        end

        if (imem_gnt) begin
            tag_d = TAG_IMEM;
        end else if (dmem_gnt && !dmem_we) begin
            tag_d = TAG_DMEM;
        end

        if (imem_rvalid) imem_hold_d = mem_rdata;
        if (dmem_rvalid) dmem_hold_d = mem_rdata;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the data holds are reset because they are visible on the rdata ports.
            starve_q    <= '0;
            tag_q       <= TAG_NONE;
            imem_hold_q <= '0;
            dmem_hold_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            starve_q    <= starve_d;
            tag_q       <= tag_d;
            imem_hold_q <= imem_hold_d;
            dmem_hold_q <= dmem_hold_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic, each cycle
// compared against a cycle-level reference model of the arbiter rules and
// a shadow copy of the memory contents.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_wstrb  (dmem_wstrb),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 32'h11) return 32'h0000_0013;
        if (i == 32'h40) return 32'h0000_0000;
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Memory environment: synchronous single-port RAM, 256 words.
    logic [31:0] env_mem [256];
    logic        fill;

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= init_word(i);
        end else if (mem_en) begin
            if (mem_we == 4'b0000) begin
                mem_rdata <= env_mem[mem_addr[7:0]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) env_mem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [256];
    int          m_starve;
    int          m_pend;      // 0 none, 1 fetch read outstanding, 2 load outstanding
    logic [31:0] m_pend_data;
    logic [31:0] m_last_i, m_last_d;

    // Observations from the latest cycle, used by directed checks.
    logic        obs_ig, obs_iv, obs_dv;
    logic [31:0] obs_drd;

    // Compare one cycle against the model, then advance the model across the edge.
    task automatic cycle();
        logic        exp_dg, exp_ig, exp_iv, exp_dv;
        logic [31:0] exp_ird, exp_drd;
        logic [3:0]  exp_we;
        logic [29:0] exp_addr;
        int          idx;
        @(negedge clk);
        exp_dg = 1'b0;
        exp_ig = 1'b0;
        if (rst) begin
            exp_dg = dmem_req && !(imem_req && m_starve >= STARVE_MAX);
            exp_ig = imem_req && !exp_dg;
        end
        exp_we   = (exp_dg && dmem_we) ? dmem_wstrb : 4'b0000;
        exp_addr = exp_dg ? dmem_addr[31:2] : imem_addr[31:2];
        exp_iv   = rst && (m_pend == 1);
        exp_dv   = rst && (m_pend == 2);
        exp_ird  = exp_iv ? m_pend_data : m_last_i;
        exp_drd  = exp_dv ? m_pend_data : m_last_d;

        check("imem_gnt", 32'(imem_gnt), 32'(exp_ig));
        check("dmem_gnt", 32'(dmem_gnt), 32'(exp_dg));
        check("mem_en", 32'(mem_en), 32'(exp_ig | exp_dg));
        if (exp_ig | exp_dg) check("mem_addr", 32'(mem_addr), 32'(exp_addr));
        check("mem_we", 32'(mem_we), 32'(exp_we));
        check("mem_wdata", mem_wdata, dmem_wdata);
        check("imem_rvalid", 32'(imem_rvalid), 32'(exp_iv));
        check("dmem_rvalid", 32'(dmem_rvalid), 32'(exp_dv));
        check("imem_rdata", imem_rdata, exp_ird);
        check("dmem_rdata", dmem_rdata, exp_drd);
        check("starve_cnt", 32'(dut.starve_q), 32'(m_starve));

        obs_ig  = imem_gnt;
        obs_iv  = imem_rvalid;
        obs_dv  = dmem_rvalid;
        obs_drd = dmem_rdata;

        if (!rst) begin
            m_starve = 0;
            m_pend   = 0;
            m_last_i = '0;
            m_last_d = '0;
        end else begin
            if (exp_iv) m_last_i = m_pend_data;
            if (exp_dv) m_last_d = m_pend_data;
            if (imem_req && !exp_ig) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : m_starve;
            else                     m_starve = 0;
            m_pend = 0;
            if (exp_ig) begin
                m_pend      = 1;
                m_pend_data = ref_mem[imem_addr[9:2]];
            end else if (exp_dg && !dmem_we) begin
                m_pend      = 2;
                m_pend_data = ref_mem[dmem_addr[9:2]];
            end else if (exp_dg) begin
                idx = int'(dmem_addr[9:2]);
                for (int b = 0; b < 4; b++)
                    if (dmem_wstrb[b]) ref_mem[idx][8*b +: 8] = dmem_wdata[8*b +: 8];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_i(input logic req, input logic [31:0] addr);
        imem_req  = req;
        imem_addr = addr;
    endtask

    task automatic set_d(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
        dmem_req   = req;
        dmem_we    = we;
        dmem_addr  = addr;
        dmem_wdata = wdata;
        dmem_wstrb = wstrb;
    endtask

    initial begin
        logic [9:0] hist;
        int         nvalid;

        rst  = 1'b0;
        fill = 1'b1;
        set_i(1'b1, 32'h0000_0044);
        set_d(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        @(posedge clk);
        #1;
        fill        = 1'b0;
        m_starve    = 0;
        m_pend      = 0;
        m_pend_data = '0;
        m_last_i    = '0;
        m_last_d    = '0;

        // Reset holds all grants and strobes low despite active requests.
        cycle();
        cycle();
        rst = 1'b1;
        set_i(1'b0, 32'h0);
        set_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycle();

        // Lone fetch of word 0x11, data returned the next cycle.
        set_i(1'b1, 32'h0000_0044);
        cycle();
        set_i(1'b0, 32'h0);
        cycle();

        // Both request: the load wins and the fetch is denied once.
        set_i(1'b1, 32'h0000_0080);
        set_d(1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'h0);
        cycle();
        set_i(1'b0, 32'h0);
        set_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycle();

        // Continuous contention: eight loads, then the starved fetch, then a load.
        hist = '0;
        set_i(1'b1, 32'h0000_0008);
        set_d(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            hist = {hist[8:0], obs_ig};
        end
        check("starve_pattern", 32'(hist), 32'(10'b00_0000_0010));
        set_i(1'b0, 32'h0);
        set_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycle();

        // Partial store followed by a load of the same word.
        set_d(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011);
        cycle();
        set_d(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
        cycle();
        set_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycle();
        check("store_low_half", 32'(obs_drd[15:0]), 32'h0000_BEEF);

        // Fetch granted, then reset on the following edge discards its data.
        set_i(1'b1, 32'h0000_0048);
        cycle();
        rst = 1'b0;
        set_d(1'b1, 1'b0, 32'h0000_0030, 32'h0, 4'h0);
        cycle();
        check("reset_drops_rvalid", 32'(obs_iv), 32'h0);
        cycle();
        rst = 1'b1;
        set_i(1'b0, 32'h0);
        set_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycle();

        // Alternating fetch and load every cycle: one return per cycle.
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                set_i(1'b1, $urandom & 32'h3FF);
                set_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            end else begin
                set_i(1'b0, 32'h0);
                set_d(1'b1, 1'b0, $urandom & 32'h3FF, 32'h0, 4'h0);
            end
            cycle();
            if (i > 0) nvalid += int'(obs_iv) + int'(obs_dv);
        end
        set_i(1'b0, 32'h0);
        set_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycle();
        nvalid += int'(obs_iv) + int'(obs_dv);
        check("alternate_returns", 32'(nvalid), 32'd8);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 31) != 0);
            set_i(($urandom_range(0, 3) != 0), $urandom & 32'h3FF);
            set_d(($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1,
                  $urandom & 32'h3FF, $urandom, 4'($urandom));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
